icache_dm: RTL
==============

Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage and the backing instruction memory.
- Fetch presents a PC every cycle. A hit returns the instruction in the same cycle.
- A miss raises stall to the hazard logic. The block then refills one line through a valid/ready memory interface and resumes.
- Also supports whole-cache invalidation (fence.i).

Parameters:
- DATA_WIDTH, 32, instruction and memory beat width.
- ADDR_WIDTH, 32, byte address width.
- NUM_LINES, 64, number of cache lines (power of 2).
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2); one memory beat per word.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  fetch request valid
- req_addr  in  ADDR_WIDTH  fetch PC (byte address; bits [1:0] ignored)
- inv  in  1  invalidate all lines (fence.i), single-cycle pulse
- resp_valid  out  1  resp_instr holds the instruction for req_addr
- resp_instr  out  DATA_WIDTH  instruction word
- stall  out  1  miss in progress; fetch must hold its PC
- mem_req_valid  out  1  line refill request
- mem_req_addr  out  ADDR_WIDTH  line-aligned refill address
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  refill beat valid
- mem_resp_data  in  DATA_WIDTH  refill beat; beats arrive in ascending word order

Behaviour:
- Address split:
  - offset = 2 + log2(WORDS_PER_LINE) bits; word select = addr[offset-1:2].
  - index = next log2(NUM_LINES) bits; tag = remaining upper bits.
- Arrays: valid[NUM_LINES] (flops), tag[NUM_LINES], data[NUM_LINES][WORDS_PER_LINE]. All have combinational read and synchronous write.
- Hit = req_valid & valid[index] & tag match & state==IDLE.
  - On a hit: resp_valid=1, resp_instr=data word, stall=0, all in the same cycle.
- stall = req_valid & ~hit. It is never asserted when req_valid=0.
- resp_valid=0 whenever stall=1. resp_instr is 0 when resp_valid=0.
- FSM states: IDLE, REQ, REFILL.
  - IDLE: on a miss, latch miss_addr = req_addr with offset bits cleared and go to REQ.
  - REQ: mem_req_valid=1, mem_req_addr=miss_addr, both held stable until mem_req_ready. On the handshake cycle go to REFILL and clear beat_cnt to 0.
  - REFILL: each mem_resp_valid writes mem_resp_data into data[miss_index][beat_cnt] and increments beat_cnt. On the beat where beat_cnt==WORDS_PER_LINE-1: write tag, set valid unless the line is poisoned, go to IDLE.
- Refill-to-hit latency: the cycle after the last beat, IDLE re-evaluates the current req_addr. If that address is in the refilled line, it hits.
- mem_req_valid is only asserted in REQ. mem_resp_valid outside REFILL is ignored.
- The current req_addr is not compared during REQ/REFILL. A redirect mid-miss does not abort the refill; the new PC is evaluated in IDLE afterwards.
- inv:
  - Clears all valid bits at the next edge; takes priority over a hit in the same cycle (that hit still returns data).
  - If inv arrives in REQ or REFILL, the in-flight line is poisoned: the refill drains fully but valid stays 0.
  - inv on the final refill beat also poisons.
- Reset, asynchronous:
  - state=IDLE, valid[*]=0, beat_cnt=0, poison=0, miss_addr=0.
  - Outputs: mem_req_valid=0, mem_req_addr=0, resp_valid=0, resp_instr=0. stall=0 until req_valid is seen.
  - Reset mid-refill abandons the refill; the memory model must be reset together with the cache.
- Tag and data contents are not reset.

Decomposition:
- Package icache_pkg: state enum (IDLE/REQ/REFILL), derived localparams OFFSET_W, INDEX_W, TAG_W, and an address-split helper function.
- One sub-module, icache_data_array: the data array plus tag storage, with combinational read and a write port of index, word, and data. icache_dm holds the valid bits, FSM, and hit logic.

Test Plan:
1. Cold miss: req 0x0000_0000; memory accepts immediately and returns beats 0x00000013, 0x00100093, 0x00200113, 0x00300193. Required: stall=1 and mem_req_addr=0x0 during the miss; the cycle after the 4th beat, resp_valid=1, resp_instr=0x00000013, stall=0.
2. Sequential hits 0x4, 0x8, 0xC after scenario 1 → resp_instr 0x00100093, 0x00200113, 0x00300193 on consecutive cycles; no mem_req_valid.
3. Conflict: req 0x400 (index 0, tag 1) → miss and refill. A following req 0x0 misses again with mem_req_addr=0x0.
4. Backpressure: mem_req_ready low for 3 cycles on a miss at 0x20 → mem_req_valid=1 and mem_req_addr=0x20 stable for all 4 cycles; exactly one handshake.
5. inv pulsed on beat 2 of the 0x20 refill → all 4 beats consumed and FSM returns to IDLE; the next req 0x20 misses again. A prior hit line (0x0) also misses.
6. rst asserted mid-REFILL, then released → mem_req_valid=0 and resp_valid=0 immediately; req 0x0 misses even though it was previously cached.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// FSM state encodings and address-split helpers.
package icache_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_REQ    = 2'd1;
    localparam state_t ST_REFILL = 2'd2;

    localparam int unsigned DEF_ADDR_WIDTH     = 32;
    localparam int unsigned DEF_NUM_LINES      = 64;
    localparam int unsigned DEF_WORDS_PER_LINE = 4;

    localparam int unsigned OFFSET_W = 2 + $clog2(DEF_WORDS_PER_LINE);
    localparam int unsigned INDEX_W  = $clog2(DEF_NUM_LINES);
    localparam int unsigned TAG_W    = DEF_ADDR_WIDTH - OFFSET_W - INDEX_W;

    // Bit position where the index field starts (byte offset + word select).
    function automatic int unsigned index_lsb(input int unsigned words_per_line);
        return 2 + $clog2(words_per_line);
    endfunction

    // Bit position where the tag field starts.
    function automatic int unsigned tag_lsb(input int unsigned words_per_line,
                                            input int unsigned num_lines);
        return index_lsb(words_per_line) + $clog2(num_lines);
    endfunction

endpackage

// File: rtl/icache_data_array.sv
// Tag and instruction storage: combinational read, one synchronous write port
// for data beats and a separate tag write strobe. Contents are not reset.
module icache_data_array
    import icache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_LINES      = 64,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned TAG_BITS       = 22
) (
    input  logic                              clk,
    input  logic [$clog2(NUM_LINES)-1:0]      rd_index_i,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] rd_word_i,
    output logic [DATA_WIDTH-1:0]             rd_data_o,
    output logic [TAG_BITS-1:0]               rd_tag_o,
    input  logic                              wr_en_i,
    input  logic [$clog2(NUM_LINES)-1:0]      wr_index_i,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] wr_word_i,
    input  logic [DATA_WIDTH-1:0]             wr_data_i,
    input  logic                              tag_we_i,
    input  logic [TAG_BITS-1:0]               wr_tag_i
);

    logic [DATA_WIDTH-1:0] data_q [NUM_LINES][WORDS_PER_LINE];
    logic [TAG_BITS-1:0]   tag_q  [NUM_LINES];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[wr_index_i][wr_word_i] <= wr_data_i;
        end
        if (tag_we_i) begin
            tag_q[wr_index_i] <= wr_tag_i;
        end
    end

    assign rd_data_o = data_q[rd_index_i][rd_word_i];
    assign rd_tag_o  = tag_q[rd_index_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: same-cycle hits, stall on miss,
// one-line refill over a valid/ready memory port, whole-cache invalidation.
module icache_dm
    import icache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned NUM_LINES      = 64,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  inv,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_instr,
    output logic                  stall,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data
);

    localparam int unsigned WSEL_W   = $clog2(WORDS_PER_LINE);
    localparam int unsigned OFF_W    = index_lsb(WORDS_PER_LINE);
    localparam int unsigned IDX_W    = $clog2(NUM_LINES);
    localparam int unsigned TAG_LO   = tag_lsb(WORDS_PER_LINE, NUM_LINES);
    localparam int unsigned TAG_BITS = ADDR_WIDTH - TAG_LO;
    localparam logic [WSEL_W-1:0] LAST_BEAT = WSEL_W'(WORDS_PER_LINE - 1);

    state_t                  state_q, state_d;
    logic [WSEL_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic                    poison_q, poison_d;
    logic [ADDR_WIDTH-1:0]   miss_addr_q, miss_addr_d;
    logic [NUM_LINES-1:0]    valid_q, valid_d;

    logic [IDX_W-1:0]        req_index;
    logic [WSEL_W-1:0]       req_word;
    logic [TAG_BITS-1:0]     req_tag;
    logic [IDX_W-1:0]        miss_index;
    logic [TAG_BITS-1:0]     miss_tag;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic [TAG_BITS-1:0]     rd_tag;
    logic                    arr_we;
    logic                    tag_we;
    logic                    hit;
    logic                    unused_byte_bits;

    assign req_word   = req_addr[2 +: WSEL_W];
    assign req_index  = req_addr[OFF_W +: IDX_W];
    assign req_tag    = req_addr[TAG_LO +: TAG_BITS];
    assign miss_index = miss_addr_q[OFF_W +: IDX_W];
    assign miss_tag   = miss_addr_q[TAG_LO +: TAG_BITS];
    assign unused_byte_bits = ^req_addr[1:0];

    icache_data_array #(
        .DATA_WIDTH     (DATA_WIDTH),
        .NUM_LINES      (NUM_LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_BITS       (TAG_BITS)
    ) u_array (
        .clk        (clk),
        .rd_index_i (req_index),
        .rd_word_i  (req_word),
        .rd_data_o  (rd_data),
        .rd_tag_o   (rd_tag),
        .wr_en_i    (arr_we),
        .wr_index_i (miss_index),
        .wr_word_i  (beat_cnt_q),
        .wr_data_i  (mem_resp_data),
        .tag_we_i   (tag_we),
        .wr_tag_i   (miss_tag)
    );

    assign hit           = req_valid && (state_q == ST_IDLE) && valid_q[req_index]
                           && (rd_tag == req_tag);
    assign stall         = req_valid && !hit;
    assign resp_valid    = hit;
    assign resp_instr    = hit ? rd_data : '0;
    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_req_addr  = (state_q == ST_REQ) ? miss_addr_q : '0;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        poison_d    = poison_q;
        miss_addr_d = miss_addr_q;
        valid_d     = valid_q;
        arr_we      = 1'b0;
        tag_we      = 1'b0;

        if (inv) begin
            valid_d = '0;
        end
        // An invalidate while a line is in flight must keep that line invalid.
        if (inv && (state_q != ST_IDLE)) begin
            poison_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (stall) begin
                    miss_addr_d = {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    poison_d    = 1'b0;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    beat_cnt_d = '0;
                    state_d    = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (mem_resp_valid) begin
                    arr_we     = 1'b1;
                    beat_cnt_d = beat_cnt_q + WSEL_W'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        tag_we  = 1'b1;
                        state_d = ST_IDLE;
                        if (!poison_q && !inv) begin
                            valid_d[miss_index] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            poison_q    <= 1'b0;
            miss_addr_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            poison_q    <= poison_d;
            miss_addr_q <= miss_addr_d;
            valid_q     <= valid_d;
        end
    end

endmodule
